// File: rtl/matrix_pkg.sv
// Shared matrix geometry and loader state type, used by the loader and the multiplier stage.
package matrix_pkg;

    localparam int BIT_SIZE             = 8;
    localparam int ROW_COL_SIZE         = 3;
    localparam int LINE_SIZE            = BIT_SIZE * ROW_COL_SIZE;
    localparam int UNPACKED_MATRIX_SIZE = LINE_SIZE * ROW_COL_SIZE;

    typedef enum logic [1:0] {
        LOAD_M1,
        LOAD_M2,
        FULL
    } loader_state_t;

endpackage

// File: rtl/matrix_pair_loader.sv
// Collects a row-major element stream into two flat N x N matrices and holds the
// completed pair until the downstream multiplier acknowledges it.
module matrix_pair_loader #(
    parameter int BIT_SIZE             = matrix_pkg::BIT_SIZE,
    parameter int ROW_COL_SIZE         = matrix_pkg::ROW_COL_SIZE,
    parameter int LINE_SIZE            = BIT_SIZE * ROW_COL_SIZE,
    parameter int UNPACKED_MATRIX_SIZE = LINE_SIZE * ROW_COL_SIZE
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [BIT_SIZE-1:0]               in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [0:UNPACKED_MATRIX_SIZE-1]   m1,
    output logic [0:UNPACKED_MATRIX_SIZE-1]   m2,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              err
);
    import matrix_pkg::*;

    localparam int ELEMS = ROW_COL_SIZE * ROW_COL_SIZE;
    localparam int CNT_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int OFF_W = (UNPACKED_MATRIX_SIZE > 1) ? $clog2(UNPACKED_MATRIX_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ELEMS - 1);

    loader_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             at_last;
    logic [OFF_W-1:0] offset;

    always_comb begin
        in_ready = (state != FULL);
        accept   = in_valid && in_ready;
        at_last  = (cnt == LAST_IDX);
        // Element index -> (row, col) -> bit position; MSB of the element sits at the lowest index.
        offset   = OFF_W'((int'(cnt) / ROW_COL_SIZE) * LINE_SIZE
                        + (int'(cnt) % ROW_COL_SIZE) * BIT_SIZE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= LOAD_M1;
            cnt       <= '0;
            m1        <= '0;
            m2        <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                LOAD_M1: begin
                    if (accept) begin
                        if (in_last) begin
                            err <= 1'b1;
                            cnt <= '0;
                        end else begin
                            m1[offset +: BIT_SIZE] <= in_data;
                            if (at_last) begin
                                cnt   <= '0;
                                state <= LOAD_M2;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                LOAD_M2: begin
                    if (accept) begin
                        if (at_last && in_last) begin
                            m2[offset +: BIT_SIZE] <= in_data;
                            cnt       <= '0;
                            state     <= FULL;
                            out_valid <= 1'b1;
                        end else if (at_last || in_last) begin
                            // Framing error: drop the partial pair and resynchronise on m1.
                            err   <= 1'b1;
                            cnt   <= '0;
                            state <= LOAD_M1;
                        end else begin
                            m2[offset +: BIT_SIZE] <= in_data;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= LOAD_M1;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD_M1;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_pair_loader.sv
// Directed bench for matrix_pair_loader: a stream-position model is compared with the
// DUT on every cycle, with literal expectations pinning the model's results.
module tb_matrix_pair_loader;

    logic        clk;
    logic        n_rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [0:71] m1;
    logic [0:71] m2;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    matrix_pair_loader #(.BIT_SIZE(8), .ROW_COL_SIZE(3)) dut (
        .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .m1(m1), .m2(m2),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    localparam logic [71:0] M1_SEQ = 72'h010203040506070809;
    localparam logic [71:0] M2_ID  = 72'h010000000100000001;

    // Model: position within the 18-element pair stream plus a "pair held" flag.
    logic [7:0] em1 [9];
    logic [7:0] em2 [9];
    int  pos  = 0;
    bit  hold = 0;
    bit  err_e = 0;

    always @(posedge clk) begin
        if (!n_rst) begin
            pos = 0; hold = 0; err_e = 0;
            for (int k = 0; k < 9; k++) begin em1[k] = '0; em2[k] = '0; end
        end else begin
            err_e = 0;
            if (hold) begin
                if (out_ready) hold = 0;
            end else if (in_valid) begin
                if (in_last != (pos == 17)) begin
                    err_e = 1;
                    pos = 0;
                end else begin
                    if (pos < 9) em1[pos] = in_data;
                    else         em2[pos-9] = in_data;
                    if (pos == 17) begin hold = 1; pos = 0; end
                    else pos++;
                end
            end
        end
    end

    function automatic logic [71:0] flat(input logic [7:0] a [9]);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[71-8*k -: 8] = a[k];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("cyc_in_ready",  72'(in_ready),  72'(!hold));
            chk("cyc_out_valid", 72'(out_valid), 72'(hold));
            chk("cyc_err",       72'(err),       72'(err_e));
            chk("cyc_m1",        m1, flat(em1));
            chk("cyc_m2",        m2, flat(em2));
        end
    end

    task automatic send(input logic [7:0] d, input bit last);
        int b = 0;
        in_valid = 1; in_data = d; in_last = last;
        while (in_ready !== 1'b1 && b < 50) begin @(negedge clk); b++; end
        if (b >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 0; in_last = 0; in_data = 8'($urandom);
    endtask

    task automatic stream(input logic [7:0] a [9], input logic [7:0] b [9],
                          input bit last_ok, input bit gaps);
        for (int k = 0; k < 18; k++) begin
            send(k < 9 ? a[k] : b[k-9], last_ok && (k == 17));
            if (gaps && k < 17) repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    logic [7:0] seq_a [9];
    logic [7:0] ident [9];
    logic [7:0] seq_c [9];
    logic [7:0] seq_d [9];

    initial begin
        for (int k = 0; k < 9; k++) begin
            seq_a[k] = 8'(k + 1);
            ident[k] = (k % 4 == 0) ? 8'h01 : 8'h00;
            seq_c[k] = 8'(17 * k + 3);
            seq_d[k] = 8'(8'hF0 + k);
        end
        n_rst = 0; in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
        repeat (2) @(negedge clk);
        run = 1;
        n_rst = 1;
        chk("reset_in_ready", 72'(in_ready), 72'd1);
        chk("reset_m1", m1, 72'd0);
        chk("reset_out_valid", 72'(out_valid), 72'd0);

        // Basic pair with immediate consumption.
        out_ready = 1;
        stream(seq_a, ident, 1, 0);
        chk("a_out_valid", 72'(out_valid), 72'd1);
        chk("a_m1_00", 72'(m1[0:7]), 72'h01);
        chk("a_m1_22", 72'(m1[64:71]), 72'h09);
        chk("a_m2_00", 72'(m2[0:7]), 72'h01);
        chk("a_m2_01", 72'(m2[8:15]), 72'h00);
        chk("a_m1", m1, M1_SEQ);
        chk("a_m2", m2, M2_ID);
        @(negedge clk);
        chk("a_out_valid_drop", 72'(out_valid), 72'd0);

        // Back-pressure: out_ready low for 5 cycles, junk offered while full.
        out_ready = 0;
        stream(seq_a, ident, 1, 0);
        in_valid = 1; in_last = 1; in_data = 8'hAA;
        for (int c = 1; c <= 6; c++) begin
            chk("b_out_valid", 72'(out_valid), 72'd1);
            chk("b_in_ready", 72'(in_ready), 72'd0);
            chk("b_m1", m1, M1_SEQ);
            if (c == 6) out_ready = 1;
            @(negedge clk);
        end
        in_valid = 0; in_last = 0;
        chk("b_released", 72'(out_valid), 72'd0);
        send(8'h11, 0);
        chk("b_next_m1_00", 72'(m1[0:7]), 72'h11);

        // in_last on the 7th m1 element.
        for (int k = 2; k <= 6; k++) send(8'(8'h10 + k), 0);
        send(8'h17, 1);
        chk("c_err", 72'(err), 72'd1);
        chk("c_out_valid", 72'(out_valid), 72'd0);
        @(negedge clk);
        chk("c_err_drop", 72'(err), 72'd0);
        stream(seq_a, ident, 1, 0);
        chk("c_pair_valid", 72'(out_valid), 72'd1);
        chk("c_m1", m1, M1_SEQ);
        chk("c_m2", m2, M2_ID);
        @(negedge clk);

        // 18 elements without in_last.
        stream(seq_c, seq_d, 0, 0);
        chk("d_err", 72'(err), 72'd1);
        chk("d_out_valid", 72'(out_valid), 72'd0);
        @(negedge clk);
        chk("d_err_drop", 72'(err), 72'd0);

        // Reset after 4 m1 elements.
        for (int k = 0; k < 4; k++) send(8'(8'hA0 + k), 0);
        n_rst = 0;
        @(negedge clk);
        n_rst = 1;
        chk("e_m1_zero", m1, 72'd0);
        chk("e_m2_zero", m2, 72'd0);
        chk("e_out_valid", 72'(out_valid), 72'd0);
        chk("e_err", 72'(err), 72'd0);
        stream(seq_c, seq_d, 1, 0);
        chk("e_pair_valid", 72'(out_valid), 72'd1);
        chk("e_m1", m1, 72'h031425364758697a8b);
        chk("e_m2", m2, 72'hf0f1f2f3f4f5f6f7f8);
        @(negedge clk);

        // Random input gaps.
        stream(seq_a, ident, 1, 1);
        chk("f_pair_valid", 72'(out_valid), 72'd1);
        chk("f_m1", m1, M1_SEQ);
        chk("f_m2", m2, M2_ID);
        repeat (3) @(negedge clk);
        run = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_pair_loader.md
MATRIX_PAIR_LOADER -- requirements
Module: matrix_pair_loader

Interface
REQ-001 The block SHALL have parameter BIT_SIZE, default 8: width of one matrix element in bits.
REQ-002 The block SHALL have parameter ROW_COL_SIZE, default 3: matrix dimension N (matrices are N x N).
REQ-003 The block SHALL have derived parameter LINE_SIZE, default BIT_SIZE*ROW_COL_SIZE: bits per matrix row.
REQ-004 The block SHALL have derived parameter UNPACKED_MATRIX_SIZE, default LINE_SIZE*ROW_COL_SIZE: bits per flat matrix.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port n_rst, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port in_data, input, BIT_SIZE bits: one element, row-major order, m1 first, then m2.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 The block SHALL have port in_last, input, 1 bit: marks the final element of m2.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-011 The block SHALL have port m1, output, [0:UNPACKED_MATRIX_SIZE-1]: flat first matrix.
REQ-012 The block SHALL have port m2, output, [0:UNPACKED_MATRIX_SIZE-1]: flat second matrix.
REQ-013 The block SHALL have port out_valid, output, 1 bit: m1 and m2 hold a complete pair.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the downstream multiplier has consumed the pair.
REQ-015 The block SHALL have port err, output, 1 bit: one-cycle pulse on a framing error.

Function
REQ-016 An element SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 Element (i,j) SHALL be written to bits [i*LINE_SIZE + j*BIT_SIZE +: BIT_SIZE]; the element MSB SHALL land at the lowest index.
REQ-018 The FSM SHALL have exactly three states: LOAD_M1, LOAD_M2 and FULL.
REQ-019 in_ready SHALL be 1 in LOAD_M1 and LOAD_M2, and 0 in FULL.
REQ-020 out_valid SHALL be 1 only in FULL.
REQ-021 The element counter SHALL run from 0 to N*N-1 and SHALL wrap to 0 on each matrix boundary.
REQ-022 LOAD_M1 SHALL transition to LOAD_M2 when element N*N-1 is accepted.
REQ-023 LOAD_M2 SHALL transition to FULL when element N*N-1 is accepted with in_last=1.
REQ-024 out_valid SHALL rise on the clock edge that accepts the final element, so latency is 0 cycles after the last handshake.
REQ-025 In FULL, the transition to LOAD_M1 with counter 0 SHALL occur on the edge where out_ready=1; the maximum rate SHALL therefore be one pair per 2*N*N+1 cycles.
REQ-026 m1 and m2 SHALL remain stable while out_valid=1.
REQ-027 Bits of m1 and m2 not yet overwritten SHALL keep their previous pair's values.
REQ-028 When in_last=1 is accepted on any element other than m2 element N*N-1, err SHALL pulse for 1 cycle and the FSM SHALL go to LOAD_M1 with counter 0, discarding the partial pair.
REQ-029 When m2 element N*N-1 is accepted with in_last=0, err SHALL pulse for 1 cycle and the FSM SHALL go to LOAD_M1 with counter 0; out_valid SHALL NOT rise.
REQ-030 A cycle with in_valid=0 SHALL leave the state, counter and data unchanged.
REQ-031 in_data and in_last SHALL be ignored when no handshake occurs.
REQ-032 out_ready SHALL be ignored outside FULL.

Reset
REQ-033 When n_rst=0 at a rising edge, the block SHALL set: state LOAD_M1, counter 0, m1=0, m2=0, out_valid=0, err=0.
REQ-034 in_ready SHALL be 1 on the first cycle after reset is released.
REQ-035 A reset asserted mid-load or in FULL SHALL discard all partial or complete data with no err pulse.

Structure
REQ-036 The shared package matrix_pkg SHALL hold BIT_SIZE, ROW_COL_SIZE, LINE_SIZE, UNPACKED_MATRIX_SIZE and the loader state enum; these SHALL also be reused by the multiplier stage.
REQ-037 The block SHALL have no sub-module; the FSM, counter and data registers SHALL be a single module, because m1 and m2 connect directly to the multiplier's flat inputs.

Verification
REQ-038 Stream m1 = 1..9 then m2 = identity (in_last on the 18th element), with out_ready=1 -> out_valid=1 for 1 cycle, m1[0:7]=8'h01, m1[64:71]=8'h09, m2[0:7]=8'h01, m2[8:15]=8'h00.
REQ-039 Same stream, with out_ready held 0 for 5 cycles -> out_valid=1 and in_ready=0 for 6 cycles, m1/m2 unchanged, next element accepted the cycle after out_ready=1.
REQ-040 Apply in_last=1 on the 7th m1 element -> err=1 for 1 cycle, out_valid stays 0, the following 18-element stream yields a correct pair.
REQ-041 Send 18 elements with in_last=0 throughout -> err pulse after the 18th, no out_valid.
REQ-042 Apply n_rst=0 for 1 cycle after 4 m1 elements -> out_valid=0, m1=0, and the next 18 elements form a fresh pair.
REQ-043 Apply random in_valid gaps (about 50% duty) -> the pair is identical to the gap-free result and in_ready never drops outside FULL.
